// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the fetch PC, captures combinational imem words into a {pc, ir} FIFO toward decode.
// Optional macro IMEM_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ir,
  output logic        out_valid,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misaligned_err
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN, ERR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_mem_pc [FIFO_DEPTH];
  logic [31:0]      r_mem_ir [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic             w_push;
  logic             w_flush;
  logic             w_misaligned;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (redirect_valid && w_misaligned) w_state_nxt = ERR;
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run          = (r_state == RUN);
    misaligned_err = (r_state == ERR);
  end

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_flush      = w_run & redirect_valid;
  assign w_pop        = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push       = w_run & fetch_en & ~redirect_valid &
                        ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  assign imem_addr = r_fetch_pc;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_mem_pc[r_rptr];
  assign out_ir    = r_mem_ir[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_mem_pc   <= '{default: '0};
      r_mem_ir   <= '{default: '0};
    end else if (w_flush) begin
      // Flush drops every entry; a same-cycle pop has already been taken by decode.
      r_fetch_pc <= redirect_pc;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wptr] <= r_fetch_pc;
        r_mem_ir[r_wptr] <= imem_ir;
        r_wptr           <= r_wptr + PTR_W'(1);
        r_fetch_pc       <= r_fetch_pc + 32'(PC_STEP);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = w_run & fetch_en & ~redirect_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push)  r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a behavioural model pushes expected {pc, ir} on fetch, pops on delivery.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_ir;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        misaligned_err;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_ir = mem_word(imem_addr);

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .PC_STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_ir        (imem_ir),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .misaligned_err (misaligned_err)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance the model, run one clock.
  task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    ent_t e;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
    check("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_err});
`ifdef IMEM_FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
    if (m_q.size() != 0 && rdy) begin
      e = m_q.pop_front();
      if (out_valid) begin
        check("out_pc", out_pc, e.pc);
        check("out_ir", out_ir, e.ir);
      end
    end
    if (!m_err) begin
      if (rv) begin
        m_q.delete();
        m_pc = rpc;
        if (rpc[1:0] != 2'b00) m_err = 1'b1;
      end else if (fe) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_pc, mem_word(m_pc)});
          m_pc    = m_pc + 32'd4;
          m_fetch = m_fetch + 32'd1;
        end else begin
          m_stall = m_stall + 32'd1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_q.delete();
    m_pc    = RESET_PC;
    m_err   = 1'b0;
    m_fetch = '0;
    m_stall = '0;
    #1;
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_ir", out_ir, 32'd0);
    check("rst_misaligned", {31'b0, misaligned_err}, 32'd0);
  endtask

  initial begin
    // Streaming with decode always ready.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Back-pressure: five stalled cycles then drain.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("bp_imem_addr", imem_addr, 32'h8);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);
`ifdef IMEM_FETCH_PERF_EN
    check("perf_fetch_7", perf_fetch_cnt, 32'd7);
    check("perf_stall_3", perf_stall_cnt, 32'd3);
`endif

    // Aligned redirect with pcs 0x4 and 0x8 buffered.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b0);
    check("redir_out_valid", {31'b0, out_valid}, 32'd0);
    check("redir_imem_addr", imem_addr, 32'h40);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Misaligned redirect, ignored follow-up redirect, then recovery via reset.
    step(1'b1, 1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("err_flag", {31'b0, misaligned_err}, 32'd1);
    check("err_addr_frozen", imem_addr, 32'h42);
    check("err_out_valid", {31'b0, out_valid}, 32'd0);
    do_reset();

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random mix of fetch enable, back-pressure and aligned redirects.
    for (int i = 0; i < 300; i++) begin
      logic        fe;
      logic        rv;
      logic        rdy;
      logic [31:0] rpc;
      fe  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      step(fe, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
